// File: rtl/tft_video_capture_pkg.sv
// Shared types and helpers for the TFT/LCD clocked-video capture block.
package tft_video_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } cap_state_t;

  // Framing flags stored alongside each pixel in the output FIFO.
  typedef struct packed {
    logic sop;
    logic eop;
  } beat_tag_t;

  function automatic logic sync_active(input logic level, input logic pol);
    return level == pol;
  endfunction

endpackage

// File: rtl/tft_video_capture_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on pop_data_o while not empty.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign pop_data_o = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/tft_video_capture.sv
// Parallel TFT/LCD video receiver: recovers frame/line framing from syncs and emits
// an Avalon-ST video stream with SOP/EOP, plus measured resolution and overflow status.
module tft_video_capture
  import tft_video_capture_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [CNT_W-1:0]  width,
  output logic [CNT_W-1:0]  height,
  output logic              frame_done,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic [1:0]        dbg_state
);

  cap_state_t        state_q, state_d;
  logic [DATA_W-1:0] vid_data_q;
  logic              dv_q, hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              sop_pend_q, sop_pend_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  width_q, width_d, height_q, height_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]  height_cand;

  logic              hs_edge, vs_edge, pixel;
  logic              push, push_eop, ovf_set;
  logic              fifo_full, fifo_empty;
  logic [DATA_W+1:0] push_entry, pop_entry;
  beat_tag_t         push_tag, pop_tag;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Edges compare the current registered sample with the previous one.
  assign hs_edge = sync_active(hs_q, HSYNC_POL) & ~sync_active(hs_prev_q, HSYNC_POL);
  assign vs_edge = sync_active(vs_q, VSYNC_POL) & ~sync_active(vs_prev_q, VSYNC_POL);
  assign pixel   = dv_q & ~sync_active(hs_q, HSYNC_POL) & ~sync_active(vs_q, VSYNC_POL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_data_q   <= '0;
      dv_q         <= 1'b0;
      hs_q         <= ~HSYNC_POL;
      vs_q         <= ~VSYNC_POL;
      hs_prev_q    <= ~HSYNC_POL;
      vs_prev_q    <= ~VSYNC_POL;
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      sop_pend_q   <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
    end else begin
      vid_data_q   <= vid_data;
      dv_q         <= vid_datavalid;
      hs_q         <= vid_h_sync;
      vs_q         <= vid_v_sync;
      hs_prev_q    <= hs_q;
      vs_prev_q    <= vs_q;
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      sop_pend_q   <= sop_pend_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      width_q      <= width_d;
      height_q     <= height_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    sop_pend_d   = sop_pend_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    push_eop     = 1'b0;
    ovf_set      = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_edge) begin
          hold_vld_d = 1'b0;
          sop_pend_d = 1'b1;
          state_d    = enable ? ACTIVE : IDLE;
        end
      end
      ACTIVE: begin
        if (vs_edge) begin
          // Flush the held pixel as the frame's last beat.
          if (hold_vld_q) begin
            push     = 1'b1;
            push_eop = 1'b1;
            if (fifo_full) ovf_set = 1'b1;
            else           frame_done_d = 1'b1;
          end
          hold_vld_d = 1'b0;
          sop_pend_d = 1'b1;
          state_d    = enable ? ACTIVE : IDLE;
        end else if (pixel) begin
          hold_d     = vid_data_q;
          hold_vld_d = 1'b1;
          if (hold_vld_q) begin
            push = 1'b1;
            if (fifo_full) begin
              ovf_set    = 1'b1;
              hold_vld_d = 1'b0;
              state_d    = DROP;
            end else begin
              sop_pend_d = 1'b0;
            end
          end
        end
      end
      DROP: begin
        hold_vld_d = 1'b0;
        if (vs_edge) begin
          sop_pend_d = 1'b1;
          state_d    = enable ? ACTIVE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A vsync edge also closes any open line so it counts toward height.
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    width_d     = width_q;
    height_d    = height_q;
    height_cand = (pix_cnt_q != '0) ? sat_inc(line_cnt_q) : line_cnt_q;
    if (vs_edge) begin
      if (pix_cnt_q != '0)   width_d  = pix_cnt_q;
      if (height_cand != '0) height_d = height_cand;
      line_cnt_d = '0;
      pix_cnt_d  = '0;
    end else if (hs_edge) begin
      if (pix_cnt_q != '0) begin
        width_d    = pix_cnt_q;
        line_cnt_d = sat_inc(line_cnt_q);
      end
      pix_cnt_d = '0;
    end else if (pixel) begin
      pix_cnt_d = sat_inc(pix_cnt_q);
    end
  end

  assign overflow_d = (overflow_q & ~clear_overflow) | ovf_set;

  assign push_tag   = '{sop: sop_pend_q, eop: push_eop};
  assign push_entry = {push_tag, hold_q};
  assign pop_tag    = pop_entry[DATA_W+1:DATA_W];

  sync_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push & ~fifo_full),
    .push_data_i (push_entry),
    .pop_i       (src_ready),
    .pop_data_o  (pop_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign src_valid  = ~fifo_empty;
  assign src_data   = src_valid ? pop_entry[DATA_W-1:0] : '0;
  assign src_sop    = src_valid & pop_tag.sop;
  assign src_eop    = src_valid & pop_tag.eop;
  assign width      = width_q;
  assign height     = height_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule
